// File: rtl/register_file_pkg.sv
// Shared MIPS datapath constants: default widths, zero-register index and
// the width of the committed-write counter. Also used by the ULA and the
// control unit.
package register_file_pkg;

  localparam int MIPS_DATA_WIDTH   = 32;
  localparam int MIPS_ADDR_WIDTH   = 5;
  localparam int MIPS_ZERO_REG     = 0;
  localparam int MIPS_WCOUNT_WIDTH = 16;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// MIPS general-purpose register file: two combinational operand read ports
// with optional same-cycle write forwarding, one unforwarded debug port,
// one write port, and a wrapping counter of committed writes.
// Register 0 is hard-wired to zero on every read path.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = MIPS_DATA_WIDTH,
  parameter int ADDR_WIDTH = MIPS_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         RegWrite,
  input  logic [ADDR_WIDTH-1:0]        WriteReg,
  input  logic [DATA_WIDTH-1:0]        WriteData,
  input  logic [ADDR_WIDTH-1:0]        ReadReg1,
  input  logic [ADDR_WIDTH-1:0]        ReadReg2,
  output logic [DATA_WIDTH-1:0]        ReadData1,
  output logic [DATA_WIDTH-1:0]        ReadData2,
  input  logic [ADDR_WIDTH-1:0]        DbgReg,
  output logic [DATA_WIDTH-1:0]        DbgData,
  output logic [MIPS_WCOUNT_WIDTH-1:0] WriteCount
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(MIPS_ZERO_REG);

  // Storage is a flop array: every entry must clear asynchronously and be
  // readable with zero latency, which rules out a block RAM.
  logic [DATA_WIDTH-1:0]        regs_reg [NUM_REGS];
  logic [MIPS_WCOUNT_WIDTH-1:0] write_count_reg;
  logic [MIPS_WCOUNT_WIDTH-1:0] write_count_next;

  // A write only counts when enabled and aimed at a real register.
  logic commit;
  assign commit = RegWrite && (WriteReg != ZERO_IDX);

  // Register array update; reset clears every entry without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (commit) begin
      regs_reg[WriteReg] <= WriteData;
    end
  end

  // Wraps naturally from all-ones back to zero.
  assign write_count_next = commit ? write_count_reg + 1'b1 : write_count_reg;

  // Committed-write counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count_reg <= '0;
    end else begin
      write_count_reg <= write_count_next;
    end
  end

  assign WriteCount = write_count_reg;

  // Operand read ports share one structure; index 0 is forced to zero ahead
  // of the forwarding mux so the bypass can never leak a value into r0.
  logic [ADDR_WIDTH-1:0] rd_idx  [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_idx[0] = ReadReg1;
  assign rd_idx[1] = ReadReg2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic hit;
      assign hit = BYPASS && commit && (rd_idx[gi] == WriteReg);
      assign rd_data[gi] = (rd_idx[gi] == ZERO_IDX) ? '0 :
                           hit                      ? WriteData :
                                                      regs_reg[rd_idx[gi]];
    end
  endgenerate

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];

  // Debug port shows committed state only, never the in-flight write.
  assign DbgData = (DbgReg == ZERO_IDX) ? '0 : regs_reg[DbgReg];

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: hand-computed vector table,
// reset/collision sequences, randomized traffic against an array model,
// and the write-counter wrap. A BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2, DbgReg;
  logic [31:0] ReadData1, ReadData2, DbgData;
  logic [15:0] WriteCount;
  logic [31:0] nb_ReadData1, nb_ReadData2, nb_DbgData;
  logic [15:0] nb_WriteCount;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: plain array of register contents plus a write count.
  logic [31:0] m_regs [32];
  logic [15:0] m_cnt;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .DbgReg(DbgReg),
    .DbgData(DbgData), .WriteCount(WriteCount)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(nb_ReadData1), .ReadData2(nb_ReadData2), .DbgReg(DbgReg),
    .DbgData(nb_DbgData), .WriteCount(nb_WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] edbg;
    logic [31:0] e1nb;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  // Expected read value straight from the rules: r0 is zero, a forwarded
  // same-cycle write wins when bypassing, otherwise the stored value.
  function automatic logic [31:0] exp_read(input logic [4:0] idx, input bit bypass);
    if (idx == 0) return 32'd0;
    if (bypass && RegWrite && WriteReg != 0 && idx == WriteReg) return WriteData;
    return m_regs[idx];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    RegWrite = we; WriteReg = wr; WriteData = wd;
    ReadReg1 = r1; ReadReg2 = r2; DbgReg = dbg;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (rst_n && RegWrite && WriteReg != 0) begin
      m_regs[WriteReg] = WriteData;
      m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rd1"},    ReadData1,     exp_read(ReadReg1, 1'b1));
    check({tag, "_rd2"},    ReadData2,     exp_read(ReadReg2, 1'b1));
    check({tag, "_dbg"},    DbgData,       exp_read(DbgReg, 1'b0));
    check({tag, "_cnt"},    {16'd0, WriteCount}, {16'd0, m_cnt});
    check({tag, "_nb_rd1"}, nb_ReadData1,  exp_read(ReadReg1, 1'b0));
    check({tag, "_nb_rd2"}, nb_ReadData2,  exp_read(ReadReg2, 1'b0));
    check({tag, "_nb_dbg"}, nb_DbgData,    exp_read(DbgReg, 1'b0));
  endtask

  initial begin
    // we  wr  wd             r1  r2   dbg  e1      e2     edbg   e1nb   cnt
    vecs[0] = '{1'b1, 5'd9,  32'd10,         5'd9, 5'd10, 5'd9,  32'd10, 32'd0,  32'd0,  32'd0,  16'd0};
    vecs[1] = '{1'b1, 5'd10, 32'd5,          5'd9, 5'd10, 5'd10, 32'd10, 32'd5,  32'd0,  32'd10, 16'd1};
    vecs[2] = '{1'b0, 5'd9,  32'hFFFF_FFFF,  5'd9, 5'd10, 5'd9,  32'd10, 32'd5,  32'd10, 32'd10, 16'd2};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF,  5'd0, 5'd0,  5'd0,  32'd0,  32'd0,  32'd0,  32'd0,  16'd2};
    vecs[4] = '{1'b0, 5'd0,  32'd0,          5'd0, 5'd9,  5'd0,  32'd0,  32'd10, 32'd0,  32'd0,  16'd2};
    vecs[5] = '{1'b1, 5'd4,  32'd7,          5'd4, 5'd9,  5'd4,  32'd7,  32'd10, 32'd0,  32'd0,  16'd2};
    vecs[6] = '{1'b1, 5'd4,  32'd20,         5'd4, 5'd4,  5'd4,  32'd20, 32'd20, 32'd7,  32'd7,  16'd3};
    vecs[7] = '{1'b0, 5'd4,  32'd0,          5'd4, 5'd4,  5'd4,  32'd20, 32'd20, 32'd20, 32'd20, 16'd4};

    rst_n = 1'b0;
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = 5'd8; ReadReg2 = 5'd9; DbgReg = 5'd10;
    model_clear();

    // Reset state, before any clock edge.
    #3;
    check("reset_rd1", ReadData1, 32'd0);
    check("reset_rd2", ReadData2, 32'd0);
    check("reset_dbg", DbgData, 32'd0);
    check("reset_cnt", {16'd0, WriteCount}, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed vector table; outputs compared before each edge.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2, vecs[i].dbg);
      $display("vec %0d: we=%0b wr=%0d wd=%h r1=%0d r2=%0d dbg=%0d -> rd1=%h rd2=%h dbg=%h nb_rd1=%h cnt=%0d",
               i, RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
               ReadData1, ReadData2, DbgData, nb_ReadData1, WriteCount);
      check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].e2);
      check($sformatf("vec%0d_dbg", i), DbgData, vecs[i].edbg);
      check($sformatf("vec%0d_nb_rd1", i), nb_ReadData1, vecs[i].e1nb);
      check($sformatf("vec%0d_nb_dbg", i), nb_DbgData, vecs[i].edbg);
      check($sformatf("vec%0d_cnt", i), {16'd0, WriteCount}, {16'd0, vecs[i].ecnt});
      clock_edge();
    end
    check("table_end_cnt", {16'd0, WriteCount}, 32'd4);

    // Asynchronous reset mid-cycle after writing r8.
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd8, 5'd0, 5'd8);
    clock_edge();
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd8);
    $display("seq async_reset: r8=%h cnt=%0d before reset", ReadData1, WriteCount);
    check("pre_reset_rd1", ReadData1, 32'hDEAD_BEEF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rd1", ReadData1, 32'd0);
    check("async_reset_dbg", DbgData, 32'd0);
    check("async_reset_cnt", {16'd0, WriteCount}, 32'd0);
    check("async_reset_nb_rd1", nb_ReadData1, 32'd0);
    model_clear();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset held across a write edge: the write is lost.
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd100; ReadReg1 = 5'd3; DbgReg = 5'd3;
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    RegWrite = 1'b0;
    rst_n = 1'b1;
    #1;
    $display("seq collision: r3=%h cnt=%0d after release", ReadData1, WriteCount);
    check("collision_rd1", ReadData1, 32'd0);
    check("collision_dbg", DbgData, 32'd0);
    check("collision_cnt", {16'd0, WriteCount}, 32'd0);
    @(posedge clk); #1;

    // First write after reset behaves as after power-up.
    drive(1'b1, 5'd3, 32'd100, 5'd3, 5'd3, 5'd3);
    check_model("post_reset_write");
    clock_edge();
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 5'd3);
    check("post_reset_r3", DbgData, 32'd100);
    check("post_reset_cnt", {16'd0, WriteCount}, 32'd1);

    // Randomized traffic against the model, biased toward read/write collisions.
    for (int t = 0; t < 300; t++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wr, $urandom(),
            ($urandom_range(0, 1) != 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) != 0) ? wr : 5'($urandom_range(0, 31)));
      $display("txn %0d: we=%0b wr=%0d wd=%h r1=%0d r2=%0d dbg=%0d -> rd1=%h rd2=%h dbg=%h cnt=%0d",
               t, RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, DbgReg,
               ReadData1, ReadData2, DbgData, WriteCount);
      check_model($sformatf("rand%0d", t));
      clock_edge();
    end

    // Counter wrap: 65536 committed writes from reset return the count to 0.
    rst_n = 1'b0;
    #1;
    model_clear();
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 65536; n++) begin
      RegWrite = 1'b1;
      WriteReg = 5'($urandom_range(1, 31));
      WriteData = $urandom();
      clock_edge();
    end
    RegWrite = 1'b0;
    #1;
    $display("seq wrap: cnt=%0d after 65536 writes", WriteCount);
    check("wrap_cnt_zero", {16'd0, WriteCount}, 32'd0);
    check("wrap_nb_cnt_zero", {16'd0, nb_WriteCount}, 32'd0);
    drive(1'b1, 5'd17, 32'h1234_5678, 5'd17, 5'd1, 5'd17);
    check_model("wrap_last");
    clock_edge();
    drive(1'b0, 5'd0, 32'd0, 5'd17, 5'd1, 5'd17);
    $display("seq wrap: cnt=%0d after one more write", WriteCount);
    check("wrap_cnt_one", {16'd0, WriteCount}, 32'd1);
    check_model("wrap_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, width of each register and of all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, 5, register index width, giving 2**ADDR_WIDTH registers.
REQ-003 SHALL have parameter BYPASS, 1, when 1 a same-cycle write to a read index is forwarded to that read port.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port RegWrite  input  1  write enable.
REQ-007 SHALL have port WriteReg  input  ADDR_WIDTH  write index.
REQ-008 SHALL have port WriteData  input  DATA_WIDTH  write value (ALUResult or memory data, selected upstream).
REQ-009 SHALL have port ReadReg1  input  ADDR_WIDTH  read index, port 1 (rs).
REQ-010 SHALL have port ReadReg2  input  ADDR_WIDTH  read index, port 2 (rt).
REQ-011 SHALL have port ReadData1  output  DATA_WIDTH  operand feeding ULA input A.
REQ-012 SHALL have port ReadData2  output  DATA_WIDTH  operand feeding ULA input B / store data.
REQ-013 SHALL have port DbgReg  input  ADDR_WIDTH  debug read index.
REQ-014 SHALL have port DbgData  output  DATA_WIDTH  debug read value; never bypassed.
REQ-015 SHALL have port WriteCount  output  16  count of committed writes to nonzero registers since reset.

Function
REQ-016 SHALL hold 2**ADDR_WIDTH registers; register 0 SHALL always read 0 on every read port, including the bypass path.
REQ-017 SHALL commit WriteData into WriteReg on a rising clk edge when RegWrite=1 and WriteReg!=0; writes to index 0 SHALL be discarded and SHALL NOT increment WriteCount.
REQ-018 SHALL provide combinational reads: ReadData1/ReadData2/DbgData reflect the addressed register with zero clock latency.
REQ-019 With BYPASS=1, ReadDataN SHALL equal WriteData whenever RegWrite=1, WriteReg!=0 and ReadRegN==WriteReg in the same cycle; with BYPASS=0 it SHALL return the pre-write value until the edge.
REQ-020 Both read ports SHALL be independent; ReadReg1==ReadReg2 SHALL return identical values.
REQ-021 WriteCount SHALL increment by 1 per committed write and SHALL wrap 16'hFFFF -> 16'h0000 without error indication.
REQ-022 Unused write cycles (RegWrite=0) SHALL leave all registers and WriteCount unchanged regardless of WriteReg/WriteData values.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately, without a clock, clear all registers and WriteCount to 0, so ReadData1, ReadData2, DbgData and WriteCount all read 0.
REQ-024 A write whose rising edge coincides with rst_n=0 SHALL be lost; reset takes priority.
REQ-025 Reset asserted mid-sequence SHALL discard all prior contents; first write after deassertion SHALL behave as after power-up.

Structure
REQ-026 DATA_WIDTH/ADDR_WIDTH defaults, the zero-register index constant and the WriteCount width SHALL live in the shared MIPS package used by ULA and the control unit.
REQ-027 SHALL be a single module with no sub-modules; the bypass comparator SHALL be local logic, not a separate block.

Verification
REQ-028 Reset: drive rst_n=0 mid-run after writing 32'hDEADBEEF to r8 -> ReadData1 (ReadReg1=8), DbgData, WriteCount read 0 before next clk edge.
REQ-029 Basic write/read: write 32'd10 to r9 and 32'd5 to r10, read ReadReg1=9, ReadReg2=10 -> 32'd10, 32'd5; WriteCount=2.
REQ-030 Zero register: RegWrite=1, WriteReg=0, WriteData=32'hFFFFFFFF, ReadReg1=0 -> ReadData1=0 same cycle and after edge; WriteCount unchanged.
REQ-031 Bypass: r4=32'd7, then RegWrite=1, WriteReg=4, WriteData=32'd20, ReadReg1=ReadReg2=4 -> both read 32'd20 before the edge (BYPASS=1), 32'd7 before the edge with BYPASS=0; DbgReg=4 reads 32'd7 before the edge in both.
REQ-032 Counter wrap: 65536 committed writes from reset -> WriteCount returns to 0; one further write -> 1.
REQ-033 Reset/edge collision: rst_n=0 across a write edge to r3 with 32'd100 -> after release r3 reads 0, WriteCount=0.
